// File: rtl/mmu_table_if.sv
// mmu_table_if: request, map-register and table-RAM pin bundle for mmu_table_ctrl
interface mmu_table_if;
    logic        lookup_req;
    logic [11:0] lookup_page;
    logic        lookup_ack;
    logic [15:0] lookup_frame;
    logic        upd_req;
    logic [15:0] upd_addr;
    logic [15:0] upd_data;
    logic        upd_ack;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [3:0]  user_map;
    logic [7:0]  supervisor_map_1;
    logic [7:0]  supervisor_map_2;
    logic [15:0] tram_addr;
    logic [15:0] tram_wdata;
    logic        tram_drive;
    logic [15:0] tram_rdata;
    logic        tram_oe_n;
    logic        tram_we_n;
    modport slave (
        input  lookup_req, lookup_page, upd_req, upd_addr, upd_data,
               cfg_we, cfg_addr, cfg_data, tram_rdata,
        output lookup_ack, lookup_frame, upd_ack, user_map, supervisor_map_1,
               supervisor_map_2, tram_addr, tram_wdata, tram_drive, tram_oe_n, tram_we_n
    );
    modport master (
        output lookup_req, lookup_page, upd_req, upd_addr, upd_data,
               cfg_we, cfg_addr, cfg_data, tram_rdata,
        input  lookup_ack, lookup_frame, upd_ack, user_map, supervisor_map_1,
               supervisor_map_2, tram_addr, tram_wdata, tram_drive, tram_oe_n, tram_we_n
    );
endinterface

// File: rtl/mmu_table_ctrl.sv
// mmu_table_ctrl: shares the page-table SRAM between translation lookups and table updates, and holds the map registers
module mmu_table_ctrl #(
    parameter int RAM_WAIT = 1
) (
    input logic        clk,
    input logic        rst,
    mmu_table_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOOKUP, UPD_SETUP, UPD_WRITE, UPD_HOLD, ACK} state_t;
    localparam logic [2:0] W = 3'(RAM_WAIT);
    state_t state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic last_upd, grant_upd, grant_lookup;
    always_comb begin
        grant_upd = state == IDLE && bus.upd_req && (!bus.lookup_req || !last_upd);
        grant_lookup = state == IDLE && bus.lookup_req && !grant_upd;
        state_nx = state;
        cnt_nx = cnt - 3'd1;
        case (state)
            IDLE: begin
                state_nx = grant_upd ? UPD_SETUP : grant_lookup ? LOOKUP : IDLE;
                cnt_nx = W;
            end
            LOOKUP: state_nx = cnt == 3'd0 ? ACK : LOOKUP;
            UPD_SETUP: begin
                state_nx = UPD_WRITE;
                cnt_nx = W;
            end
            UPD_WRITE: state_nx = cnt == 3'd0 ? UPD_HOLD : UPD_WRITE;
            UPD_HOLD: state_nx = ACK;
            default: state_nx = IDLE;
        endcase
    end
    // last_upd doubles as the ack selector: it always names the access now in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            last_upd <= 1'b1;
            bus.lookup_frame <= '0;
            bus.tram_addr <= '0;
            bus.tram_wdata <= '0;
            bus.user_map <= '0;
            bus.supervisor_map_1 <= '0;
            bus.supervisor_map_2 <= '0;
        end else begin
            state <= state_nx;
            cnt <= cnt_nx;
            if (grant_upd || grant_lookup) last_upd <= grant_upd;
            if (grant_lookup) bus.tram_addr <= {bus.user_map, bus.lookup_page};
            if (grant_upd) begin
                bus.tram_addr <= bus.upd_addr;
                bus.tram_wdata <= bus.upd_data;
            end
            if (state == LOOKUP && cnt == 3'd0) bus.lookup_frame <= bus.tram_rdata;
            if (bus.cfg_we && bus.cfg_addr == 2'd0) bus.user_map <= bus.cfg_data[3:0];
            if (bus.cfg_we && bus.cfg_addr == 2'd1) bus.supervisor_map_1 <= bus.cfg_data;
            if (bus.cfg_we && bus.cfg_addr == 2'd2) bus.supervisor_map_2 <= bus.cfg_data;
        end
    end
    // pin strobes decode straight from the state register so reset releases the bus at once
    assign bus.tram_oe_n = state != LOOKUP;
    assign bus.tram_we_n = state != UPD_WRITE;
    assign bus.tram_drive = state == UPD_SETUP || state == UPD_WRITE || state == UPD_HOLD;
    assign bus.lookup_ack = state == ACK && !last_upd;
    assign bus.upd_ack = state == ACK && last_upd;
endmodule

// File: tb/tb_mmu_table_ctrl.sv
// tb_mmu_table_ctrl: directed and randomized check of mmu_table_ctrl against a transaction-timeline model
module tb_mmu_table_ctrl;
    localparam int W = 1;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    mmu_table_if bus ();
    mmu_table_ctrl #(.RAM_WAIT(W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // model: one access at a time, k = cycles since its grant edge
    bit busy, kind, last_upd;
    int k;
    logic [15:0] e_addr, e_wdata, e_frame;
    logic [3:0] e_umap;
    logic [7:0] e_s1, e_s2;
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] dev [logic [15:0]];

    function automatic logic [15:0] fill(input logic [15:0] a);
        return (a * 16'd7) ^ 16'hC3A5;
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        busy = 0;
        kind = 0;
        k = 0;
        last_upd = 1;
        e_addr = '0;
        e_wdata = '0;
        e_frame = '0;
        e_umap = '0;
        e_s1 = '0;
        e_s2 = '0;
    endtask

    task automatic model_edge();
        if (!busy) begin
            if (bus.lookup_req || bus.upd_req) begin
                kind = bus.upd_req && (!bus.lookup_req || !last_upd);
                last_upd = kind;
                busy = 1;
                k = 0;
                if (kind) begin
                    e_addr = bus.upd_addr;
                    e_wdata = bus.upd_data;
                end else e_addr = {e_umap, bus.lookup_page};
            end
        end else begin
            k++;
            if (!kind && k == W + 1) e_frame = ref_mem.exists(e_addr) ? ref_mem[e_addr] : fill(e_addr);
            if (kind && k == W + 3) ref_mem[e_addr] = e_wdata;
            if (k == (kind ? W + 4 : W + 2)) busy = 0;
        end
        if (bus.cfg_we && bus.cfg_addr == 2'd0) e_umap = bus.cfg_data[3:0];
        if (bus.cfg_we && bus.cfg_addr == 2'd1) e_s1 = bus.cfg_data;
        if (bus.cfg_we && bus.cfg_addr == 2'd2) e_s2 = bus.cfg_data;
    endtask

    // external SRAM: writes while we_n is low, presents data while oe_n is low
    task automatic dev_io();
        if (!bus.tram_we_n) dev[bus.tram_addr] = bus.tram_wdata;
        bus.tram_rdata = !bus.tram_oe_n ? (dev.exists(bus.tram_addr) ? dev[bus.tram_addr] : fill(bus.tram_addr)) : 16'hDEAD;
    endtask

    task automatic compare();
        chk("lookup_ack", 32'(bus.lookup_ack), 32'(busy && !kind && k == W + 1));
        chk("upd_ack", 32'(bus.upd_ack), 32'(busy && kind && k == W + 3));
        chk("tram_oe_n", 32'(bus.tram_oe_n), 32'(!(busy && !kind && k <= W)));
        chk("tram_we_n", 32'(bus.tram_we_n), 32'(!(busy && kind && k >= 1 && k <= W + 1)));
        chk("tram_drive", 32'(bus.tram_drive), 32'(busy && kind && k <= W + 2));
        chk("tram_addr", 32'(bus.tram_addr), 32'(e_addr));
        chk("tram_wdata", 32'(bus.tram_wdata), 32'(e_wdata));
        chk("lookup_frame", 32'(bus.lookup_frame), 32'(e_frame));
        chk("user_map", 32'(bus.user_map), 32'(e_umap));
        chk("supervisor_map_1", 32'(bus.supervisor_map_1), 32'(e_s1));
        chk("supervisor_map_2", 32'(bus.supervisor_map_2), 32'(e_s2));
        chk("oe_we_exclusive", 32'(bus.tram_oe_n | bus.tram_we_n), 32'd1);
        chk("drive_while_oe", 32'(bus.tram_drive & !bus.tram_oe_n), 32'd0);
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        dev_io();
        compare();
    endtask

    task automatic wait_ack(input bit upd, input string n);
        int i;
        for (i = 0; i < 40 && !(upd ? bus.upd_ack : bus.lookup_ack); i++) step();
        chk(n, 32'(i < 40), 32'd1);
    endtask

    task automatic chk_reset(input string n);
        chk({n, "_acks"}, 32'({bus.lookup_ack, bus.upd_ack}), 32'd0);
        chk({n, "_frame"}, 32'(bus.lookup_frame), 32'd0);
        chk({n, "_maps"}, 32'({bus.user_map, bus.supervisor_map_1, bus.supervisor_map_2}), 32'd0);
        chk({n, "_addr_wdata"}, {bus.tram_addr, bus.tram_wdata}, 32'd0);
        chk({n, "_drive_oe_we"}, 32'({bus.tram_drive, bus.tram_oe_n, bus.tram_we_n}), 32'b011);
    endtask

    initial begin
        bit kinds [$];
        int times [$];
        bus.lookup_req = 0;
        bus.lookup_page = '0;
        bus.upd_req = 0;
        bus.upd_addr = '0;
        bus.upd_data = '0;
        bus.cfg_we = 0;
        bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus.tram_rdata = 16'hDEAD;
        model_reset();
        #1 rst = 1;
        #1 chk_reset("reset_init");
        @(negedge clk);
        rst = 0;
        dev_io();
        compare();
        // both requesters raised together: lookup first, then strict alternation
        bus.lookup_req = 1;
        bus.lookup_page = 12'h001;
        bus.upd_req = 1;
        bus.upd_addr = 16'h0011;
        bus.upd_data = 16'h5555;
        step();
        chk("arb_first_is_lookup", 32'({bus.tram_oe_n, bus.tram_drive}), 32'b00);
        for (int i = 0; i < 60 && kinds.size() < 4; i++) begin
            step();
            if (bus.lookup_ack || bus.upd_ack) begin
                kinds.push_back(bus.upd_ack);
                times.push_back(i);
            end
        end
        bus.lookup_req = 0;
        bus.upd_req = 0;
        chk("arb_ack_count", 32'(kinds.size()), 32'd4);
        if (kinds.size() == 4) begin
            chk("arb_order", 32'({kinds[0], kinds[1], kinds[2], kinds[3]}), 32'b0101);
            chk("arb_lookup_to_upd", 32'(times[1] - times[0]), 32'd6);
            chk("arb_upd_to_lookup", 32'(times[2] - times[1]), 32'd4);
        end
        step();
        step();
        // lookup with user_map=4, page 0x002
        bus.cfg_we = 1;
        bus.cfg_addr = 2'd0;
        bus.cfg_data = 8'h04;
        step();
        bus.cfg_we = 0;
        dev[16'h4002] = 16'h1234;
        ref_mem[16'h4002] = 16'h1234;
        bus.lookup_req = 1;
        bus.lookup_page = 12'h002;
        step();
        chk("lk_addr", 32'(bus.tram_addr), 32'h4002);
        chk("lk_oe_1", 32'(bus.tram_oe_n), 32'd0);
        step();
        chk("lk_oe_2", 32'(bus.tram_oe_n), 32'd0);
        step();
        chk("lk_ack", 32'({bus.tram_oe_n, bus.lookup_ack}), 32'b11);
        chk("lk_frame", 32'(bus.lookup_frame), 32'h1234);
        bus.lookup_req = 0;
        step();
        chk("lk_ack_once", 32'(bus.lookup_ack), 32'd0);
        // update 0x1005 <= 0xBEEF
        bus.upd_req = 1;
        bus.upd_addr = 16'h1005;
        bus.upd_data = 16'hBEEF;
        step();
        chk("up_setup", 32'({bus.tram_drive, bus.tram_we_n, bus.tram_oe_n}), 32'b111);
        chk("up_setup_bus", {bus.tram_addr, bus.tram_wdata}, 32'h1005BEEF);
        step();
        chk("up_write_1", 32'({bus.tram_drive, bus.tram_we_n}), 32'b10);
        step();
        chk("up_write_2", 32'({bus.tram_drive, bus.tram_we_n}), 32'b10);
        step();
        chk("up_hold", 32'({bus.tram_drive, bus.tram_we_n, bus.upd_ack}), 32'b110);
        step();
        chk("up_ack", 32'({bus.tram_drive, bus.upd_ack}), 32'b01);
        chk("up_wdata", 32'(bus.tram_wdata), 32'hBEEF);
        bus.upd_req = 0;
        step();
        chk("up_ack_once", 32'(bus.upd_ack), 32'd0);
        // user_map rewritten mid-lookup must not disturb the address in flight
        bus.cfg_we = 1;
        bus.cfg_data = 8'h01;
        step();
        bus.cfg_we = 0;
        bus.lookup_req = 1;
        bus.lookup_page = 12'h003;
        step();
        chk("mid_addr_grant", 32'(bus.tram_addr), 32'h1003);
        bus.cfg_we = 1;
        bus.cfg_data = 8'h07;
        step();
        chk("mid_addr_wait", 32'(bus.tram_addr), 32'h1003);
        bus.cfg_we = 0;
        step();
        chk("mid_addr_ack", 32'({bus.tram_addr, 15'd0, bus.lookup_ack}), 32'h10030001);
        bus.lookup_req = 0;
        step();
        bus.lookup_req = 1;
        step();
        chk("mid_next_addr", 32'(bus.tram_addr), 32'h7003);
        wait_ack(1'b0, "mid_next_ack");
        bus.lookup_req = 0;
        step();
        // asynchronous reset during the write pulse
        bus.cfg_we = 1;
        bus.cfg_addr = 2'd1;
        bus.cfg_data = 8'hAA;
        step();
        bus.cfg_we = 0;
        bus.upd_req = 1;
        bus.upd_addr = 16'h2222;
        bus.upd_data = 16'h7777;
        step();
        step();
        chk("rst_in_write", 32'(bus.tram_we_n), 32'd0);
        @(posedge clk);
        #2 rst = 1;
        #1 chk_reset("reset_async");
        model_reset();
        @(negedge clk);
        rst = 0;
        dev_io();
        compare();
        wait_ack(1'b1, "reissue_ack");
        chk("reissue_wdata", 32'(bus.tram_wdata), 32'h7777);
        bus.upd_req = 0;
        step();
        // randomized traffic on a small address space so lookups revisit updated entries
        for (int i = 0; i < 3000; i++) begin
            if (bus.lookup_ack) bus.lookup_req = 0;
            if (bus.upd_ack) bus.upd_req = 0;
            if (!bus.lookup_req && $urandom_range(2) == 0) begin
                bus.lookup_req = 1;
                bus.lookup_page = 12'($urandom_range(7));
            end
            if (!bus.upd_req && $urandom_range(3) == 0) begin
                bus.upd_req = 1;
                bus.upd_addr = {4'($urandom_range(3)), 12'($urandom_range(7))};
                bus.upd_data = 16'($urandom);
            end
            bus.cfg_we = $urandom_range(7) == 0;
            bus.cfg_addr = 2'($urandom_range(3));
            bus.cfg_data = 8'($urandom) & (bus.cfg_addr == 2'd0 ? 8'h03 : 8'hFF);
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmu_table_ctrl.md
Name: mmu_table_ctrl

Overview:
- Sequences the external page-table SRAM that backs user-mode translation in the MMU.
- Shares that SRAM between two requesters:
  - user-mode translation lookups issued for CPU bus cycles;
  - supervisor page-table updates.
- Also owns the user_map, supervisor_map_1 and supervisor_map_2 configuration registers that feed the MMU.
- Sits between the bus glue/CPU register port and the table RAM pins.

Parameters:
- RAM_WAIT, 1: extra cycles that oe_n or we_n is held low beyond the first; legal range 0..7.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- lookup_req  in  1  translation request; held high until lookup_ack
- lookup_page  in  12  logical page bits [23:12], stable while lookup_req is high
- lookup_ack  out  1  one-cycle pulse: lookup_frame valid
- lookup_frame  out  16  physical frame bits [27:12] from table RAM
- upd_req  in  1  table write request; held high until upd_ack
- upd_addr  in  16  table RAM word address
- upd_data  in  16  table entry value
- upd_ack  out  1  one-cycle pulse: write complete
- cfg_we  in  1  map register write strobe
- cfg_addr  in  2  0=user_map, 1=supervisor_map_1, 2=supervisor_map_2, 3=no effect
- cfg_data  in  8  write data; user_map takes [3:0]
- user_map  out  4  current user task map
- supervisor_map_1  out  8  supervisor map register 1
- supervisor_map_2  out  8  supervisor map register 2
- tram_addr  out  16  table RAM address, registered
- tram_wdata  out  16  table RAM write data, registered
- tram_drive  out  1  enables tram_wdata onto the shared RAM data bus
- tram_rdata  in  16  table RAM read data
- tram_oe_n  out  1  RAM output enable, active low
- tram_we_n  out  1  RAM write enable, active low

Behaviour:
- Reset, asynchronous:
  - state=IDLE; all registers and outputs 0, except tram_oe_n=1 and tram_we_n=1;
  - last_grant=UPDATE, so a lookup wins the first tie.
- Reset mid-operation:
  - tram_oe_n and tram_we_n go high and tram_drive goes low immediately;
  - no ack is issued; requesters re-issue after reset.
- Let W = RAM_WAIT.
- Config writes:
  - the register selected by cfg_addr updates on the edge where cfg_we=1;
  - accepted in every state.
- States: IDLE, LOOKUP, UPD_SETUP, UPD_WRITE, UPD_HOLD, ACK.
- IDLE:
  - only lookup pending: grant lookup.
  - only upd pending: grant update.
  - both pending: grant the kind not in last_grant; update last_grant on each grant.
- LOOKUP, entered on the grant edge:
  - tram_addr <= {user_map, lookup_page}, latched at the grant; later user_map writes do not affect an in-flight lookup;
  - tram_oe_n=0 for exactly W+1 cycles;
  - on the last edge, lookup_frame <= tram_rdata, then go to ACK with lookup_ack=1;
  - lookup_frame holds until the next lookup completes.
- UPD_SETUP, 1 cycle:
  - tram_addr <= upd_addr, tram_wdata <= upd_data;
  - tram_drive=1, tram_we_n=1.
- UPD_WRITE, W+1 cycles:
  - tram_we_n=0, tram_drive=1; tram_addr and tram_wdata stable.
- UPD_HOLD, 1 cycle:
  - tram_we_n=1, tram_drive=1; then go to ACK with upd_ack=1.
- ACK, 1 cycle:
  - exactly one of lookup_ack or upd_ack is high;
  - no new grant; requests are ignored this cycle;
  - returns to IDLE.
- tram_drive is never 1 while tram_oe_n=0.
- tram_oe_n and tram_we_n are never both 0.
- Latency, request high before edge 0 with no contention:
  - lookup_ack high in the cycle after edge W+1;
  - upd_ack high in the cycle after edge W+3.
- Counter: 3-bit wait counter, loaded with W on entry to LOOKUP or UPD_WRITE and decremented each cycle; the state exits when it reaches 0.
- A request that drops before its ack is a protocol violation; the controller completes the access and acks anyway.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs zero, tram_oe_n=1, tram_we_n=1, tram_drive=0 with no clock edge needed.
- W=1: cfg write user_map=4, then lookup_page=0x002 with tram_rdata=0x1234:
  - tram_addr=0x4002;
  - tram_oe_n low exactly 2 cycles;
  - lookup_ack one cycle later, lookup_frame=0x1234.
- W=1: update addr=0x1005, data=0xBEEF:
  - 1 setup cycle with drive=1, we_n=1;
  - 2 cycles we_n=0;
  - 1 hold cycle;
  - upd_ack one cycle; tram_wdata=0xBEEF throughout.
- Arbitration: lookup_req and upd_req raised on the same edge after reset:
  - lookup served first, then the update, no IDLE gap beyond ACK;
  - repeat with both held: grants alternate update, lookup, update.
- Mid-lookup cfg write of user_map=7 with lookup_page=0x003, initial user_map=1:
  - tram_addr stays 0x1003 for the whole lookup;
  - next lookup uses 0x7xxx.
- Assert rst during UPD_WRITE:
  - tram_we_n goes 1 and tram_drive goes 0 asynchronously; upd_ack never pulses;
  - after release, the re-issued update completes normally.
